// File: rtl/rover_move_executor_pkg.sv
// Shared definitions for the rover move executor: FSM state codes,
// motor drive codes, move_command field layout and the angle decoder.
package rover_move_executor_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TURN   = 3'd1,
        S_SETTLE = 3'd2,
        S_DRIVE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MOTOR_FWD  = 2'b10;
    localparam logic [1:0] MOTOR_REV  = 2'b01;
    localparam logic [1:0] MOTOR_STOP = 2'b00;

    localparam int ANGLE_MSB = 11;
    localparam int ANGLE_LSB = 7;
    localparam int DIST_MSB  = 6;
    localparam int DIST_LSB  = 0;

    // One full revolution in 15-degree steps.
    localparam int unsigned ANGLE_STEPS_FULL = 24;

    typedef struct packed {
        logic       valid;
        logic       left;
        logic [3:0] steps;
    } turn_t;

    // Codes past half a revolution mean "turn left by the remainder";
    // codes at or beyond a full revolution are rejected.
    function automatic turn_t decode_angle(input logic [4:0] angle);
        turn_t t;
        t = '0;
        if (angle <= 5'd12) begin
            t.valid = 1'b1;
            t.steps = angle[3:0];
        end else if (angle < 5'(ANGLE_STEPS_FULL)) begin
            t.valid = 1'b1;
            t.left  = 1'b1;
            t.steps = 4'(5'(ANGLE_STEPS_FULL) - angle);
        end
        return t;
    endfunction

endpackage

// File: rtl/rover_move_executor_if.sv
// Command handshake bundle for the rover move executor.
// cmd_valid/move_command flow master->slave, cmd_ready flows back.
interface rover_move_executor_if;

    logic        cmd_valid;
    logic [11:0] move_command;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output move_command,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  move_command,
        output cmd_ready
    );

endinterface

// File: rtl/rover_move_executor_tick_prescaler.sv
// Divides the clock down to one-cycle motion ticks every TICK_DIV cycles.
// Ports: clock, reset (sync, high), i_enable, i_clear, o_tick.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 270000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_count;

    assign o_tick = i_enable && (r_count == LAST);

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_tick ? '0 : r_count + PW'(1);
        end
    end

endmodule

// File: rtl/rover_move_executor.sv
// Executes one turn-then-drive move command at a time.
// Ports: clock, reset (sync, high), cmd (handshake slave), abort,
//        motor_left/right, busy, move_done, cmd_error, state (debug).
module rover_move_executor
    import rover_move_executor_pkg::*;
#(
    parameter int unsigned TICK_DIV             = 270000,
    parameter int unsigned TURN_TICKS_PER_STEP  = 8,
    parameter int unsigned DRIVE_TICKS_PER_UNIT = 4,
    parameter int unsigned SETTLE_TICKS         = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    rover_move_executor_if.slave cmd,
    input  logic                 abort,
    output logic [1:0]           motor_left,
    output logic [1:0]           motor_right,
    output logic                 busy,
    output logic                 move_done,
    output logic                 cmd_error,
    output logic [2:0]           state
);

    state_t      r_state;
    logic [1:0]  r_motor_l;
    logic [1:0]  r_motor_r;
    logic        r_done;
    logic        r_error;
    logic [3:0]  r_steps;
    logic        r_left;
    logic [6:0]  r_dist;
    logic [15:0] r_ticks;

    turn_t       w_turn;
    logic [6:0]  w_dist;
    logic        w_accept;
    logic        w_active;
    logic        w_tick;
    logic        w_phase_end;
    logic        w_clear;
    logic [31:0] w_target;

    assign w_turn   = decode_angle(cmd.move_command[ANGLE_MSB:ANGLE_LSB]);
    assign w_dist   = cmd.move_command[DIST_MSB:DIST_LSB];
    assign w_accept = cmd.cmd_valid && (r_state == S_IDLE) && !abort;
    assign w_active = (r_state == S_TURN) || (r_state == S_SETTLE)
                   || (r_state == S_DRIVE);

    always_comb begin
        w_target = '0;
        unique case (r_state)
            S_TURN:   w_target = 32'(r_steps) * 32'(TURN_TICKS_PER_STEP);
            S_SETTLE: w_target = 32'(SETTLE_TICKS);
            S_DRIVE:  w_target = 32'(r_dist) * 32'(DRIVE_TICKS_PER_UNIT);
            default:  w_target = '0;
        endcase
    end

    // The phase ends on the tick that completes its tick budget.
    assign w_phase_end = w_tick && (({16'd0, r_ticks} + 32'd1) >= w_target);
    // Counters restart at every phase boundary and idle at zero,
    // so a freshly accepted command always starts from a clean count.
    assign w_clear     = !w_active || w_phase_end;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .i_enable (w_active),
        .i_clear  (w_clear),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_ticks <= '0;
        end else if (w_tick) begin
            r_ticks <= r_ticks + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_motor_l <= MOTOR_STOP;
            r_motor_r <= MOTOR_STOP;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_steps   <= '0;
            r_left    <= 1'b0;
            r_dist    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_motor_l <= MOTOR_STOP;
                r_motor_r <= MOTOR_STOP;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_accept && !w_turn.valid) begin
                            r_error <= 1'b1;
                        end else if (w_accept) begin
                            r_steps <= w_turn.steps;
                            r_left  <= w_turn.left;
                            r_dist  <= w_dist;
                            if (w_turn.steps != 4'd0) begin
                                r_state   <= S_TURN;
                                r_motor_l <= w_turn.left ? MOTOR_REV : MOTOR_FWD;
                                r_motor_r <= w_turn.left ? MOTOR_FWD : MOTOR_REV;
                            end else if (w_dist != 7'd0) begin
                                r_state   <= S_DRIVE;
                                r_motor_l <= MOTOR_FWD;
                                r_motor_r <= MOTOR_FWD;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_TURN: begin
                        if (w_phase_end) begin
                            r_state   <= S_SETTLE;
                            r_motor_l <= MOTOR_STOP;
                            r_motor_r <= MOTOR_STOP;
                        end
                    end
                    S_SETTLE: begin
                        if (w_phase_end && (r_dist != 7'd0)) begin
                            r_state   <= S_DRIVE;
                            r_motor_l <= MOTOR_FWD;
                            r_motor_r <= MOTOR_FWD;
                        end else if (w_phase_end) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DRIVE: begin
                        if (w_phase_end) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_motor_l <= MOTOR_STOP;
                            r_motor_r <= MOTOR_STOP;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_motor_l <= MOTOR_STOP;
                        r_motor_r <= MOTOR_STOP;
                    end
                endcase
            end
        end
    end

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign motor_left    = r_motor_l;
    assign motor_right   = r_motor_r;
    assign move_done     = r_done;
    assign cmd_error     = r_error;
    assign state         = r_state;

endmodule
